// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types and constants for the pipeline tracker.
//   stage_t    : contents of one tracked pipeline stage {v, id, pc, inst}
//   ID_W       : width of the instruction sequence ID (wraps 0x7FFFFFFF -> 0)
//   KILL_DEPTH : number of kill reports that can be pending at once
// -----------------------------------------------------------------------------
package trace_pkg;

    localparam int XLEN       = 32;
    localparam int ID_W       = 31;
    localparam int KILL_DEPTH = 2;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

    // Sequence IDs are presented as 32-bit integers on the trace ports.
    function automatic logic [XLEN-1:0] id_to_int(input logic [ID_W-1:0] id);
        return {{(XLEN-ID_W){1'b0}}, id};
    endfunction

endpackage

// File: rtl/pipe_tracker_killq.sv
// -----------------------------------------------------------------------------
// pipe_tracker_killq
// Two-entry FIFO of killed instruction IDs. A flush may kill two instructions
// in the same cycle (X and I); they are reported one per cycle, X first.
// Only present when PIPE_TRACK_KONATA_EN is defined; otherwise this file is
// empty so no unreferenced module is left in the build.
//
// Ports:
//   clk, reset      : clock, synchronous active-low reset (clears all entries)
//   push_a, id_a    : first entry to enqueue this cycle (older instruction)
//   push_b, id_b    : second entry to enqueue this cycle (younger instruction)
//   kill_v, kill_id : head of queue; shown for one cycle and then dropped.
//                     kill_id is 0 whenever kill_v is 0.
// -----------------------------------------------------------------------------
`ifdef PIPE_TRACK_KONATA_EN
module pipe_tracker_killq
    import trace_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            push_a,
    input  logic [ID_W-1:0] id_a,
    input  logic            push_b,
    input  logic [ID_W-1:0] id_b,
    output logic            kill_v,
    output logic [XLEN-1:0] kill_id
);

    logic [ID_W-1:0] ent_q [KILL_DEPTH];
    logic [ID_W-1:0] ent_n [KILL_DEPTH];
    logic [1:0]      cnt_q;
    logic [1:0]      cnt_n;

    always_comb begin
        ent_n[0] = ent_q[0];
        ent_n[1] = ent_q[1];
        cnt_n    = cnt_q;
        // The head is reported every cycle it is valid, so it always retires.
        if (cnt_q != 2'd0) begin
            ent_n[0] = ent_q[1];
            cnt_n    = cnt_q - 2'd1;
        end
        // Append in age order: a (from X) before b (from I).
        if (push_a) begin
            if (cnt_n == 2'd0) begin
                ent_n[0] = id_a;
                cnt_n    = 2'd1;
            end else if (cnt_n == 2'd1) begin
                ent_n[1] = id_a;
                cnt_n    = 2'd2;
            end
        end
        if (push_b) begin
            if (cnt_n == 2'd0) begin
                ent_n[0] = id_b;
                cnt_n    = 2'd1;
            end else if (cnt_n == 2'd1) begin
                ent_n[1] = id_b;
                cnt_n    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= 2'd0;
            ent_q[0] <= '0;
            ent_q[1] <= '0;
        end else begin
            cnt_q    <= cnt_n;
            ent_q[0] <= ent_n[0];
            ent_q[1] <= ent_n[1];
        end
    end

    assign kill_v  = (cnt_q != 2'd0);
    assign kill_id = kill_v ? id_to_int(ent_q[0]) : '0;

endmodule
`endif

// File: rtl/pipe_tracker.sv
// -----------------------------------------------------------------------------
// pipe_tracker
// Shadows a 4-stage pipeline (I, X, M, R) for instruction tracing. Each stage
// holds {v, id, pc, inst}. stall holds I and X and drops a bubble into M;
// flush (priority over stall) kills I and X. R retires what M held.
//
// Optional feature macro: PIPE_TRACK_KONATA_EN
//   defined   : sequence IDs, stage-entry pulses, per-stage IDs and kill
//               reports are produced.
//   undefined : ID storage and kill queue are absent; inst_v_*, c*, inst_k
//               and ck are tied to 0. valid/pc/inst, rdv and pcv unchanged.
//
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   i_valid, i_pc, i_inst      : instruction presented to I this cycle
//   stall, flush               : pipeline hold / wrong-path kill
//   x_pcv, x_pc                : redirect from X (registered to pcv/pc_x)
//   m_rdv, m_rd, m_rd_data     : M write-back (registered to rdv/rd_m/rd_data)
//   valid, pc, inst            : instruction retiring from R
//   inst_v_i/x/m/r             : new valid instruction entered that stage
//   ci, cx, cm, cr             : sequence ID held in I/X/M/R
//   inst_k, ck                 : killed-instruction report and its ID
// -----------------------------------------------------------------------------
module pipe_tracker
    import trace_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_inst,
    input  logic            stall,
    input  logic            flush,
    input  logic            x_pcv,
    input  logic [XLEN-1:0] x_pc,
    input  logic            m_rdv,
    input  logic [4:0]      m_rd,
    input  logic [XLEN-1:0] m_rd_data,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst,
    output logic            rdv,
    output logic [4:0]      rd_m,
    output logic [XLEN-1:0] rd_data,
    output logic            pcv,
    output logic [XLEN-1:0] pc_x,
    output logic            inst_v_i,
    output logic            inst_v_x,
    output logic            inst_v_m,
    output logic            inst_v_r,
    output logic [XLEN-1:0] ci,
    output logic [XLEN-1:0] cx,
    output logic [XLEN-1:0] cm,
    output logic [XLEN-1:0] cr,
    output logic            inst_k,
    output logic [XLEN-1:0] ck
);

    stage_t          stg_i_p0, stg_x_p1, stg_m_p2, stg_r_p3;
    stage_t          stg_i_n,  stg_x_n,  stg_m_n;
    logic [ID_W-1:0] id_in;

`ifdef PIPE_TRACK_KONATA_EN
    logic [ID_W-1:0] next_id;
    logic            ent_i_p0, ent_x_p1;
    logic            ent_i_n,  ent_x_n;

    // An instruction is consumed (and numbered) when I would load, which
    // includes a flush cycle even though the instruction is then discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            next_id <= '0;
        end else if (i_valid && (flush || !stall)) begin
            next_id <= next_id + ID_W'(1);
        end
    end

    assign id_in = next_id;
`else
    assign id_in = '0;
`endif

    always_comb begin
        stg_i_n = stg_i_p0;
        stg_x_n = stg_x_p1;
        stg_m_n = STAGE_EMPTY;
`ifdef PIPE_TRACK_KONATA_EN
        ent_i_n = 1'b0;
        ent_x_n = 1'b0;
`endif
        if (flush) begin
            // Wrong path: I and X die, and X does not advance into M.
            stg_i_n.v = 1'b0;
            stg_x_n.v = 1'b0;
        end else if (!stall) begin
            stg_i_n = '{v: i_valid, id: id_in, pc: i_pc, inst: i_inst};
            stg_x_n = stg_i_p0;
            stg_m_n = stg_x_p1;
`ifdef PIPE_TRACK_KONATA_EN
            ent_i_n = i_valid;
            ent_x_n = stg_i_p0.v;
`endif
        end
    end

    // ---- I (p0) / X (p1) / M (p2) / R (p3) stage registers ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            stg_i_p0 <= STAGE_EMPTY;
            stg_x_p1 <= STAGE_EMPTY;
            stg_m_p2 <= STAGE_EMPTY;
            stg_r_p3 <= STAGE_EMPTY;
        end else begin
            stg_i_p0 <= stg_i_n;
            stg_x_p1 <= stg_x_n;
            stg_m_p2 <= stg_m_n;
            stg_r_p3 <= stg_m_p2;
        end
    end

    assign valid = stg_r_p3.v;
    assign pc    = stg_r_p3.pc;
    assign inst  = stg_r_p3.inst;

    // ---- registered side-band copies (1-cycle latency) ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdv     <= 1'b0;
            rd_m    <= '0;
            rd_data <= '0;
            pcv     <= 1'b0;
            pc_x    <= '0;
        end else begin
            rdv     <= m_rdv && (m_rd != 5'd0);  // x0 writes are not real
            rd_m    <= m_rd;
            rd_data <= m_rd_data;
            pcv     <= x_pcv;
            pc_x    <= x_pc;
        end
    end

`ifdef PIPE_TRACK_KONATA_EN
    // Entry flags are cleared on a hold so a stalled instruction pulses once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ent_i_p0 <= 1'b0;
            ent_x_p1 <= 1'b0;
        end else begin
            ent_i_p0 <= ent_i_n;
            ent_x_p1 <= ent_x_n;
        end
    end

    assign inst_v_i = ent_i_p0;
    assign inst_v_x = ent_x_p1;
    // M and R reload every cycle, so any valid content there is new.
    assign inst_v_m = stg_m_p2.v;
    assign inst_v_r = stg_r_p3.v;
    assign ci       = id_to_int(stg_i_p0.id);
    assign cx       = id_to_int(stg_x_p1.id);
    assign cm       = id_to_int(stg_m_p2.id);
    assign cr       = id_to_int(stg_r_p3.id);

    pipe_tracker_killq u_killq (
        .clk     (clk),
        .reset   (reset),
        .push_a  (flush && stg_x_p1.v),
        .id_a    (stg_x_p1.id),
        .push_b  (flush && stg_i_p0.v),
        .id_b    (stg_i_p0.id),
        .kill_v  (inst_k),
        .kill_id (ck)
    );
`else
    // IDs are constant zero in this build; R's copy has no consumer.
    logic unused_r_id;
    assign unused_r_id = ^stg_r_p3.id;

    assign inst_v_i = 1'b0;
    assign inst_v_x = 1'b0;
    assign inst_v_m = 1'b0;
    assign inst_v_r = 1'b0;
    assign ci       = '0;
    assign cx       = '0;
    assign cm       = '0;
    assign cr       = '0;
    assign inst_k   = 1'b0;
    assign ck       = '0;
`endif

endmodule
